// File: rtl/vc_fill_ctrl.sv
// vc_fill_ctrl: fill/replacement controller for an 8-way fully associative victim cache.
//
// An evicted L1 line is written into one VC way. The destination way is picked in this order:
//   1. the swap way, if the eviction is half of a VC hit;
//   2. otherwise the lowest-index invalid way;
//   3. otherwise the way the FIFO pointer selects.
// If the line being displaced is valid and dirty, it is written back to memory first.
// The block also owns the per-way tag/valid/dirty state that the hit-compare logic reads.
//
// Ports:
//   clk, rst (asynchronous, active low)
//   evict_valid/evict_ready  - handshake with L1. evict_addr, evict_dirty, evict_hit and
//                              evict_hit_way describe the line.
//   wb_req/wb_addr/wb_way    - write-back request to memory, held until wb_ack.
//   vc_datastore_read        - data store read enable, high while a write-back is pending.
//   vc_datastore_ld_mask     - one-hot data store write strobe.
//   way_valid/way_dirty/way_tags - per-way state. Way i's tag is at [i*s_vtag +: s_vtag].
//   dbg_state/dbg_ptr        - FSM state and FIFO replacement pointer, for observation only.
//
// Handshake: L1 raises evict_valid and holds every evict_* input (and the line data) stable
// until the cycle where evict_valid & evict_ready. evict_ready is high only in the single
// WRITE cycle, so the transfer completes in that cycle. If L1 drops evict_valid early, that is
// a protocol error; the transaction still finishes using the inputs captured at the start.
module vc_fill_ctrl #(
  parameter int s_offset   = 5,
  parameter int s_vtag     = 32 - s_offset,
  parameter int size_of_vc = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         evict_valid,
  output logic                         evict_ready,
  input  logic [s_vtag-1:0]            evict_addr,
  input  logic                         evict_dirty,
  input  logic                         evict_hit,
  input  logic [size_of_vc-1:0]        evict_hit_way,
  output logic                         wb_req,
  output logic [s_vtag-1:0]            wb_addr,
  output logic [size_of_vc-1:0]        wb_way,
  input  logic                         wb_ack,
  output logic                         vc_datastore_read,
  output logic [size_of_vc-1:0]        vc_datastore_ld_mask,
  output logic [size_of_vc-1:0]        way_valid,
  output logic [size_of_vc-1:0]        way_dirty,
  output logic [size_of_vc*s_vtag-1:0] way_tags,
  output logic [1:0]                   dbg_state,
  output logic [$clog2(size_of_vc)-1:0] dbg_ptr
);

  localparam int way_w = $clog2(size_of_vc);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                              state_q, state_d;
  logic [way_w-1:0]                    tgt_q, tgt_d;
  logic                                from_ptr_q, from_ptr_d;
  logic [s_vtag-1:0]                   addr_q, addr_d;
  logic                                edirty_q, edirty_d;
  logic [way_w-1:0]                    ptr_q, ptr_d;
  logic [size_of_vc-1:0]               valid_q, valid_d;
  logic [size_of_vc-1:0]               dirty_q, dirty_d;
  logic [size_of_vc-1:0][s_vtag-1:0]   tags_q, tags_d;

  // Candidate-way selection. Each loop runs from the highest index down to 0,
  // so the lowest index that matches is the one left in the result.
  logic [way_w-1:0] hit_idx, inv_idx, sel_idx;
  logic             use_hit, inv_any, sel_from_ptr;

  always_comb begin
    hit_idx = '0;
    inv_idx = '0;
    for (int i = size_of_vc - 1; i >= 0; i--) begin
      if (evict_hit_way[i]) hit_idx = i[way_w-1:0];
      if (!valid_q[i])      inv_idx = i[way_w-1:0];
    end
    // A hit flag with an empty way vector is treated as an ordinary miss.
    use_hit      = evict_hit && (evict_hit_way != '0);
    inv_any      = ~&valid_q;
    sel_from_ptr = 1'b0;
    if (use_hit) begin
      sel_idx = hit_idx;
    end else if (inv_any) begin
      sel_idx = inv_idx;
    end else begin
      sel_idx      = ptr_q;
      sel_from_ptr = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      from_ptr_q <= 1'b0;
      addr_q     <= '0;
      edirty_q   <= 1'b0;
      ptr_q      <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      tags_q     <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      from_ptr_q <= from_ptr_d;
      addr_q     <= addr_d;
      edirty_q   <= edirty_d;
      ptr_q      <= ptr_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      tags_q     <= tags_d;
    end
  end

  // Next-state logic; the way-state update happens when WRITE ends
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    from_ptr_d = from_ptr_q;
    addr_d     = addr_q;
    edirty_d   = edirty_q;
    ptr_d      = ptr_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tags_d     = tags_q;
    case (state_q)
      IDLE: begin
        if (evict_valid) begin
          addr_d     = evict_addr;
          edirty_d   = evict_dirty;
          tgt_d      = sel_idx;
          from_ptr_d = sel_from_ptr;
          // A swap way never needs a write-back: its line is moving to L1.
          if (!use_hit && valid_q[sel_idx] && dirty_q[sel_idx]) state_d = WB;
          else                                                  state_d = WRITE;
        end
      end
      WB: begin
        if (wb_ack) state_d = WRITE;
      end
      WRITE: begin
        state_d        = IDLE;
        tags_d[tgt_q]  = addr_q;
        valid_d[tgt_q] = 1'b1;
        dirty_d[tgt_q] = edirty_q;
        if (from_ptr_q) ptr_d = ptr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: each output is nonzero only in its own state
  logic [size_of_vc-1:0] tgt_onehot;
  assign tgt_onehot = {{(size_of_vc-1){1'b0}}, 1'b1} << tgt_q;

  always_comb begin
    evict_ready          = 1'b0;
    wb_req               = 1'b0;
    wb_addr              = '0;
    wb_way               = '0;
    vc_datastore_read    = 1'b0;
    vc_datastore_ld_mask = '0;
    case (state_q)
      WB: begin
        wb_req            = 1'b1;
        wb_addr           = tags_q[tgt_q];
        wb_way            = tgt_onehot;
        vc_datastore_read = 1'b1;
      end
      WRITE: begin
        evict_ready          = 1'b1;
        vc_datastore_ld_mask = tgt_onehot;
      end
      default: ;
    endcase
  end

  assign way_valid = valid_q;
  assign way_dirty = dirty_q;
  assign way_tags  = tags_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_vc_fill_ctrl.sv
// Testbench for vc_fill_ctrl.
// A transaction-level model of the victim cache (per-way arrays plus a FIFO pointer) predicts
// the outputs for every cycle. One negedge process compares the DUT against those predictions.
module tb_vc_fill_ctrl;
  localparam int AW = 27;
  localparam int NW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           evict_valid, evict_ready, evict_dirty, evict_hit, wb_ack;
  logic [AW-1:0]  evict_addr, wb_addr;
  logic [NW-1:0]  evict_hit_way, wb_way, ld_mask, way_valid, way_dirty;
  logic           wb_req, ds_read;
  logic [NW*AW-1:0] way_tags;
  logic [1:0]     dbg_state;
  logic [2:0]     dbg_ptr;

  vc_fill_ctrl dut (
    .clk(clk), .rst(rst),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_addr(evict_addr), .evict_dirty(evict_dirty),
    .evict_hit(evict_hit), .evict_hit_way(evict_hit_way),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_way(wb_way), .wb_ack(wb_ack),
    .vc_datastore_read(ds_read), .vc_datastore_ld_mask(ld_mask),
    .way_valid(way_valid), .way_dirty(way_dirty), .way_tags(way_tags),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  // reference model
  logic [AW-1:0] m_tags[NW];
  bit            m_valid[NW];
  bit            m_dirty[NW];
  int            m_ptr;
  int            tgt_log[$];

  // expected outputs for the current cycle
  logic          exp_ready, exp_wb_req, exp_read;
  logic [AW-1:0] exp_wb_addr;
  logic [NW-1:0] exp_wb_way, exp_ld;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  chk_en   = 0;
  int  wb_seen  = 0;
  logic [AW-1:0] last_wb_addr = '0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      m_tags[i] = '0; m_valid[i] = 0; m_dirty[i] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic set_idle();
    exp_ready = 0; exp_wb_req = 0; exp_read = 0;
    exp_wb_addr = '0; exp_wb_way = '0; exp_ld = '0;
  endtask

  // Target-way rule: swap way, then the first invalid way, then the FIFO way.
  function automatic int pick(input bit h, input logic [NW-1:0] hw, output bit fp);
    int  r;
    bit  found;
    fp = 0; found = 0; r = 0;
    if (h && hw != 0) begin
      for (int i = 0; i < NW; i++) if (!found && hw[i]) begin r = i; found = 1; end
    end
    if (!found) begin
      for (int i = 0; i < NW; i++) if (!found && !m_valid[i]) begin r = i; found = 1; end
    end
    if (!found) begin r = m_ptr; fp = 1; end
    return r;
  endfunction

  // compare process
  always @(negedge clk) begin
    logic [NW-1:0]    ev, ed;
    logic [NW*AW-1:0] et;
    if (chk_en) begin
      for (int i = 0; i < NW; i++) begin
        ev[i] = m_valid[i];
        ed[i] = m_dirty[i];
        et[i*AW +: AW] = m_tags[i];
      end
      chk("evict_ready", 256'(evict_ready), 256'(exp_ready));
      chk("wb_req", 256'(wb_req), 256'(exp_wb_req));
      chk("wb_addr", 256'(wb_addr), 256'(exp_wb_addr));
      chk("wb_way", 256'(wb_way), 256'(exp_wb_way));
      chk("ds_read", 256'(ds_read), 256'(exp_read));
      chk("ld_mask", 256'(ld_mask), 256'(exp_ld));
      chk("way_valid", 256'(way_valid), 256'(ev));
      chk("way_dirty", 256'(way_dirty), 256'(ed));
      chk("way_tags", 256'(way_tags), 256'(et));
      chk("fifo_ptr", 256'(dbg_ptr), 256'(m_ptr));
      if (wb_req) begin
        wb_seen++;
        last_wb_addr = wb_addr;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle (#1 after a posedge) and returns #1 after the edge that ends WRITE.
  task automatic fill(input logic [AW-1:0] a, input bit d, input bit h,
                      input logic [NW-1:0] hw, input int ack_dly);
    int t;
    bit fp, wb;
    evict_valid = 1; evict_addr = a; evict_dirty = d;
    evict_hit = h; evict_hit_way = hw; wb_ack = 0;
    t  = pick(h, hw, fp);
    wb = !(h && hw != 0) && m_valid[t] && m_dirty[t];
    tgt_log.push_back(t);
    set_idle();
    step();
    if (wb) begin
      for (int i = 0; i <= ack_dly; i++) begin
        exp_wb_req = 1; exp_wb_addr = m_tags[t]; exp_wb_way = NW'(1) << t; exp_read = 1;
        wb_ack = (i == ack_dly);
        step();
      end
      wb_ack = 0;
    end
    set_idle();
    exp_ready = 1; exp_ld = NW'(1) << t;
    step();
    m_tags[t] = a; m_valid[t] = 1; m_dirty[t] = d;
    if (fp) m_ptr = (m_ptr + 1) % NW;
    set_idle();
    evict_valid = 0;
  endtask

  logic [AW-1:0] ra;
  logic [NW-1:0] rhw;
  int            w0;

  initial begin
    evict_valid = 0; evict_addr = '0; evict_dirty = 0; evict_hit = 0;
    evict_hit_way = '0; wb_ack = 0;
    model_reset();
    set_idle();
    step();
    chk_en = 1;
    step(); step();
    chk("reset_valid", 256'(way_valid), 256'(0));
    chk("reset_ready", 256'(evict_ready), 256'(0));
    rst = 1;
    step();

    // eight clean fills land in ways 0..7 in order
    for (int i = 0; i < NW; i++) fill(AW'(32'h100 + i), 0, 0, '0, 0);
    for (int i = 0; i < NW; i++) chk("fill_order", 256'(tgt_log[i]), 256'(i));
    chk("fill8_valid", 256'(way_valid), 256'(8'hFF));
    chk("fill8_ptr", 256'(dbg_ptr), 256'(0));

    // ninth fill replaces way 0 via the FIFO pointer
    fill(AW'(32'hB0B), 0, 0, '0, 0);
    chk("fill9_tag0", 256'(way_tags[AW-1:0]), 256'(32'hB0B));
    chk("fill9_ptr", 256'(dbg_ptr), 256'(1));
    chk("fill9_no_wb", 256'(wb_seen), 256'(0));

    // make way 1 dirty through a swap, then a fill to ptr=1 forces a write-back
    fill(AW'(32'hD1), 1, 1, 8'h02, 0);
    chk("swap1_ptr", 256'(dbg_ptr), 256'(1));
    w0 = wb_seen;
    fill(AW'(32'hC0C), 0, 0, '0, 3);
    chk("wb_cycles", 256'(wb_seen - w0), 256'(4));
    chk("wb_addr_last", 256'(last_wb_addr), 256'(32'hD1));
    chk("wbfill_tag1", 256'(way_tags[1*AW +: AW]), 256'(32'hC0C));

    // swap into a dirty way 4: no write-back, pointer unchanged
    fill(AW'(32'hE4), 1, 1, 8'h10, 0);
    w0 = wb_seen;
    fill(AW'(32'hF4), 1, 1, 8'h10, 0);
    chk("swap4_no_wb", 256'(wb_seen - w0), 256'(0));
    chk("swap4_ptr", 256'(dbg_ptr), 256'(2));
    chk("swap4_tag", 256'(way_tags[4*AW +: AW]), 256'(32'hF4));

    // a hit flag with an empty way vector behaves as a miss (FIFO way 2)
    fill(AW'(32'h66), 0, 1, 8'h00, 0);
    chk("hit0_tag2", 256'(way_tags[2*AW +: AW]), 256'(32'h66));
    chk("hit0_ptr", 256'(dbg_ptr), 256'(3));

    // reset while a write-back is pending
    fill(AW'(32'h77), 1, 1, 8'h08, 0);
    evict_valid = 1; evict_addr = AW'(32'h88); evict_dirty = 0; evict_hit = 0;
    evict_hit_way = '0; wb_ack = 0;
    set_idle();
    step();
    exp_wb_req = 1; exp_wb_addr = AW'(32'h77); exp_wb_way = 8'h08; exp_read = 1;
    @(negedge clk);
    #1;
    rst = 0; evict_valid = 0;
    model_reset();
    set_idle();
    #1;
    chk("rst_wb_req", 256'(wb_req), 256'(0));
    step();
    rst = 1;
    step();
    chk("rst_valid", 256'(way_valid), 256'(0));

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      ra = AW'($urandom);
      case ($urandom_range(0, 9))
        0:       rhw = '0;
        1:       rhw = NW'($urandom_range(1, 255));
        default: rhw = NW'(1) << $urandom_range(0, 7);
      endcase
      fill(ra, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), rhw,
           $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) step();
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
